// File: rtl/cmsdk_rst_sequencer.sv
// cmsdk_rst_sequencer: staged POR -> AHB -> APB reset release with sticky reset-cause record.
// Define CMSDK_RST_LOCKUP_EN to make LOCKUP & LOCKUPRESET a reset request.
module cmsdk_rst_sequencer #(
    parameter int POR_CYCLES = 16,
    parameter int SYS_CYCLES = 8,
    parameter int APB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       SYSRESETREQ,
    input  logic       WDOGRESREQ,
    input  logic       LOCKUP,
    input  logic       LOCKUPRESET,
    input  logic       RSTINFOCLR,
    output logic       PORESETn,
    output logic       HRESETn,
    output logic       PRESETn,
    output logic [3:0] RSTINFO
);
    typedef enum logic [1:0] {POR, HOLD_SYS, HOLD_APB, RUN} state_t;

    localparam logic [7:0] POR_LAST = 8'(POR_CYCLES - 1);
    localparam logic [7:0] SYS_LAST = 8'(SYS_CYCLES - 1);
    localparam logic [7:0] APB_LAST = 8'(APB_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       poresetn_q, poresetn_d;
    logic       hresetn_q, hresetn_d;
    logic       presetn_q, presetn_d;
    logic [3:0] rstinfo_q, rstinfo_d;
    logic       lockup_req;
    logic       req;
    logic [3:0] cause;

`ifdef CMSDK_RST_LOCKUP_EN
    assign lockup_req = LOCKUP & LOCKUPRESET;
`else
    logic unused_lockup;
    assign unused_lockup = LOCKUP ^ LOCKUPRESET;
    assign lockup_req    = 1'b0;
`endif

    assign cause = {lockup_req, WDOGRESREQ, SYSRESETREQ, 1'b0};
    assign req   = |cause;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        poresetn_d = poresetn_q;
        hresetn_d  = hresetn_q;
        presetn_d  = presetn_q;
        rstinfo_d  = (RSTINFOCLR ? 4'b0000 : rstinfo_q) | ((state_q != POR) ? cause : 4'b0000);
        case (state_q)
            POR: if (cnt_q == POR_LAST) begin
                poresetn_d = 1'b1;
                state_d    = HOLD_SYS;
                cnt_d      = 8'd0;
            end
            HOLD_SYS: if (cnt_q == SYS_LAST) begin
                hresetn_d = 1'b1;
                state_d   = HOLD_APB;
                cnt_d     = 8'd0;
            end
            HOLD_APB: if (cnt_q == APB_LAST) begin
                presetn_d = 1'b1;
                state_d   = RUN;
            end
            default: cnt_d = cnt_q;
        endcase
        // A request outside POR restarts the system hold, also when already holding.
        if (state_q != POR && req) begin
            state_d   = HOLD_SYS;
            cnt_d     = 8'd0;
            hresetn_d = 1'b0;
            presetn_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q    <= POR;
            cnt_q      <= 8'd0;
            poresetn_q <= 1'b0;
            hresetn_q  <= 1'b0;
            presetn_q  <= 1'b0;
            rstinfo_q  <= 4'b0001;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poresetn_q <= poresetn_d;
            hresetn_q  <= hresetn_d;
            presetn_q  <= presetn_d;
            rstinfo_q  <= rstinfo_d;
        end
    end

    assign PORESETn = poresetn_q;
    assign HRESETn  = hresetn_q;
    assign PRESETn  = presetn_q;
    assign RSTINFO  = rstinfo_q;
endmodule

// File: tb/tb_cmsdk_rst_sequencer.sv
// tb_cmsdk_rst_sequencer: directed and random checks against a timestamp-based reference model.
module tb_cmsdk_rst_sequencer;
    localparam int POR = 16, SYS = 8, APB = 4;
`ifdef CMSDK_RST_LOCKUP_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic CLK = 1'b0, NRST = 1'b0, SYSRESETREQ = 1'b0, WDOGRESREQ = 1'b0;
    logic LOCKUP = 1'b0, LOCKUPRESET = 1'b0, RSTINFOCLR = 1'b0;
    logic PORESETn, HRESETn, PRESETn;
    logic [3:0] RSTINFO;

    int total = 0, bad = 0;

    // Model: release times are derived from edge timestamps, not from a state machine.
    int t = 0, n_high = 0, base = -1000;
    bit m_por = 0, m_h = 0, m_p = 0;
    logic [3:0] m_info = 4'b0001;

    cmsdk_rst_sequencer #(.POR_CYCLES(POR), .SYS_CYCLES(SYS), .APB_CYCLES(APB)) dut (
        .CLK(CLK), .NRST(NRST), .SYSRESETREQ(SYSRESETREQ), .WDOGRESREQ(WDOGRESREQ),
        .LOCKUP(LOCKUP), .LOCKUPRESET(LOCKUPRESET), .RSTINFOCLR(RSTINFOCLR),
        .PORESETn(PORESETn), .HRESETn(HRESETn), .PRESETn(PRESETn), .RSTINFO(RSTINFO)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        logic [3:0] c;
        bit was_por;
        @(posedge CLK);
        t++;
        was_por = m_por;
        if (!NRST) begin
            n_high = 0;
            m_info = 4'b0001;
            base = -1000;
        end else begin
            n_high++;
            c = {LK & LOCKUP & LOCKUPRESET, WDOGRESREQ, SYSRESETREQ, 1'b0};
            m_info = (RSTINFOCLR ? 4'b0000 : m_info) | (was_por ? c : 4'b0000);
            if (was_por && |c) base = t;
            if (n_high == POR) base = t;
        end
        m_por = n_high >= POR;
        m_h = m_por && (t - base >= SYS);
        m_p = m_por && (t - base >= SYS + APB);
        #1;
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== 7'b000_0001) begin
                bad++;
                $display("FAIL reset_hold got=%b want=0000001", {PORESETn, HRESETn, PRESETn, RSTINFO});
            end
        end
        NRST = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== {k >= 16, k >= 24, k >= 28, 4'b0001}) begin
                bad++;
                $display("FAIL por_seq edge=%0d got=%b want=%b", k, {PORESETn, HRESETn, PRESETn, RSTINFO},
                         {k >= 16, k >= 24, k >= 28, 4'b0001});
            end
        end
    endtask

    task automatic test_sysreq();
        SYSRESETREQ = 1'b1;
        tick();
        SYSRESETREQ = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn} !== {1'b1, k >= 8, k >= 12}) begin
                bad++;
                $display("FAIL sysreq k=%0d got=%b want=%b", k, {PORESETn, HRESETn, PRESETn}, {1'b1, k >= 8, k >= 12});
            end
        end
        total++;
        if (RSTINFO !== 4'b0011) begin
            bad++;
            $display("FAIL sysreq_info got=%b want=0011", RSTINFO);
        end
    endtask

    task automatic test_wdog();
        WDOGRESREQ = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        WDOGRESREQ = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (HRESETn !== (k >= 8) || PRESETn !== (k >= 12)) begin
                bad++;
                $display("FAIL wdog_hold k=%0d got=%b%b want=%b%b", k, HRESETn, PRESETn, k >= 8, k >= 12);
            end
        end
        total++;
        if (RSTINFO[2] !== 1'b1) begin
            bad++;
            $display("FAIL wdog_info got=%b want=1", RSTINFO[2]);
        end
        RSTINFOCLR = 1'b1;
        tick();
        RSTINFOCLR = 1'b0;
        total++;
        if (RSTINFO !== 4'b0000) begin
            bad++;
            $display("FAIL info_clear got=%b want=0000", RSTINFO);
        end
    endtask

    task automatic test_nrst_mid();
        NRST = 1'b0;
        tick();
        NRST = 1'b1;
        for (int i = 0; i < 26; i++) tick();
        NRST = 1'b0;
        tick();
        NRST = 1'b1;
        total++;
        if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== 7'b000_0001) begin
            bad++;
            $display("FAIL mid_reset got=%b want=0000001", {PORESETn, HRESETn, PRESETn, RSTINFO});
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== {k >= 16, k >= 24, k >= 28, 4'b0001}) begin
                bad++;
                $display("FAIL mid_seq edge=%0d got=%b want=%b", k, {PORESETn, HRESETn, PRESETn, RSTINFO},
                         {k >= 16, k >= 24, k >= 28, 4'b0001});
            end
        end
    endtask

    task automatic test_lockup();
        LOCKUP = 1'b1;
        LOCKUPRESET = 1'b1;
        tick();
        LOCKUP = 1'b0;
        LOCKUPRESET = 1'b0;
        total++;
        if ({PORESETn, HRESETn, PRESETn} !== {1'b1, !LK, !LK}) begin
            bad++;
            $display("FAIL lockup_resp got=%b want=%b", {PORESETn, HRESETn, PRESETn}, {1'b1, !LK, !LK});
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== {m_por, m_h, m_p, m_info}) begin
                bad++;
                $display("FAIL lockup_seq got=%b want=%b", {PORESETn, HRESETn, PRESETn, RSTINFO}, {m_por, m_h, m_p, m_info});
            end
        end
        total++;
        if (RSTINFO[3] !== LK) begin
            bad++;
            $display("FAIL lockup_info got=%b want=%b", RSTINFO[3], LK);
        end
    endtask

    task automatic test_clr_collide();
        NRST = 1'b0;
        tick();
        NRST = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        WDOGRESREQ = 1'b1;
        tick();
        WDOGRESREQ = 1'b0;
        total++;
        if (RSTINFO !== 4'b0101) begin
            bad++;
            $display("FAIL collide_pre got=%b want=0101", RSTINFO);
        end
        for (int i = 0; i < 14; i++) tick();
        RSTINFOCLR = 1'b1;
        SYSRESETREQ = 1'b1;
        tick();
        RSTINFOCLR = 1'b0;
        SYSRESETREQ = 1'b0;
        total++;
        if (RSTINFO !== 4'b0010) begin
            bad++;
            $display("FAIL collide got=%b want=0010", RSTINFO);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            NRST = ($urandom_range(63) != 0);
            SYSRESETREQ = ($urandom_range(23) == 0);
            WDOGRESREQ = ($urandom_range(23) == 0);
            LOCKUP = ($urandom_range(7) == 0);
            LOCKUPRESET = ($urandom_range(1) == 0);
            RSTINFOCLR = ($urandom_range(7) == 0);
            tick();
            total++;
            if ({PORESETn, HRESETn, PRESETn, RSTINFO} !== {m_por, m_h, m_p, m_info}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, {PORESETn, HRESETn, PRESETn, RSTINFO}, {m_por, m_h, m_p, m_info});
            end
        end
        {SYSRESETREQ, WDOGRESREQ, LOCKUP, LOCKUPRESET, RSTINFOCLR} = 5'b0;
        NRST = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_sysreq();
        test_wdog();
        test_nrst_mid();
        test_lockup();
        test_clr_collide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
